classifier_argmax: RTL

Final stage of the LeNet datapath, directly downstream of the third convolution layer. Accepts the 10 signed class scores (`featuremap3`) in one valid/ready handshake, buffers them, and scans them sequentially, one per cycle. Reports the winning class index, the top two scores, their margin and a confidence flag. The result is held until the consumer accepts it.

---
 rtl/lenet_pkg.sv | 16 +
 rtl/max2_update.sv | 30 +++
 rtl/classifier_argmax.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet datapath types: class count, score type and the argmax FSM states.
package lenet_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned CLASS_W     = 4;
    localparam int unsigned SCORE_W     = 16;

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/max2_update.sv
// Combinational top-2 tracker step: folds one incoming score into (best, second, idx).
module max2_update #(
    parameter int unsigned W  = 16,
    parameter int unsigned IW = 4
) (
    input  logic signed [W-1:0]  i_score,
    input  logic        [IW-1:0] i_score_idx,
    input  logic signed [W-1:0]  i_best,
    input  logic signed [W-1:0]  i_second,
    input  logic        [IW-1:0] i_idx,
    output logic signed [W-1:0]  o_best_c,
    output logic signed [W-1:0]  o_second_c,
    output logic        [IW-1:0] o_idx_c
);

    // Strict compares keep the earliest index on ties.
    always_comb begin
        o_best_c   = i_best;
        o_second_c = i_second;
        o_idx_c    = i_idx;
        if (i_score > i_best) begin
            o_second_c = i_best;
            o_best_c   = i_score;
            o_idx_c    = i_score_idx;
        end else if (i_score > i_second) begin
            o_second_c = i_score;
        end
    end

endmodule

// File: rtl/classifier_argmax.sv
// Final LeNet stage: buffers 10 class scores, scans them one per cycle and
// holds the winning index, top-2 scores, margin and confidence until accepted.
module classifier_argmax
    import lenet_pkg::*;
#(
    parameter int unsigned bitwidth    = 16,
    parameter int unsigned conf_thresh = 256
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic signed [NUM_CLASSES-1:0][bitwidth-1:0] featuremap3,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic        [CLASS_W-1:0]                   class_idx,
    output logic signed [bitwidth-1:0]                  max_score,
    output logic signed [bitwidth-1:0]                  second_score,
    output logic        [bitwidth:0]                    margin,
    output logic                                        confident
);

    localparam int unsigned MW = bitwidth + 1;

    argmax_state_t             r_state;
    logic [bitwidth-1:0]       r_buf [NUM_CLASSES];
    logic signed [bitwidth-1:0] r_best;
    logic signed [bitwidth-1:0] r_second;
    logic [CLASS_W-1:0]        r_idx;
    logic [CLASS_W-1:0]        r_cnt;

    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [CLASS_W-1:0]        r_class_idx;
    logic signed [bitwidth-1:0] r_max_score;
    logic signed [bitwidth-1:0] r_second_score;
    logic [MW-1:0]             r_margin;
    logic                      r_confident;

    logic                      w_scanning;
    logic [CLASS_W-1:0]        w_rd_idx;
    logic signed [bitwidth-1:0] w_best;
    logic signed [bitwidth-1:0] w_second;
    logic [CLASS_W-1:0]        w_idx;
    logic [MW-1:0]             w_margin;
    logic                      w_confident;

    // Counter reaches NUM_CLASSES after the last score; that extra SCAN cycle registers the result.
    assign w_scanning = (r_cnt < CLASS_W'(NUM_CLASSES));
    assign w_rd_idx   = w_scanning ? r_cnt : '0;

    max2_update #(
        .W  (bitwidth),
        .IW (CLASS_W)
    ) u_max2 (
        .i_score     ($signed(r_buf[w_rd_idx])),
        .i_score_idx (r_cnt),
        .i_best      (r_best),
        .i_second    (r_second),
        .i_idx       (r_idx),
        .o_best_c    (w_best),
        .o_second_c  (w_second),
        .o_idx_c     (w_idx)
    );

    // Sign-extend both operands so the full signed range cannot overflow.
    assign w_margin    = {r_best[bitwidth-1], r_best} - {r_second[bitwidth-1], r_second};
    assign w_confident = (w_margin >= MW'(conf_thresh));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            for (int i = 0; i < NUM_CLASSES; i++) r_buf[i] <= '0;
            r_best         <= '0;
            r_second       <= '0;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_class_idx    <= '0;
            r_max_score    <= '0;
            r_second_score <= '0;
            r_margin       <= '0;
            r_confident    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        for (int i = 0; i < NUM_CLASSES; i++) r_buf[i] <= featuremap3[i];
                        r_best     <= featuremap3[0];
                        r_second   <= {1'b1, {(bitwidth-1){1'b0}}};
                        r_idx      <= '0;
                        r_cnt      <= CLASS_W'(1);
                        r_in_ready <= 1'b0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_scanning) begin
                        r_best   <= w_best;
                        r_second <= w_second;
                        r_idx    <= w_idx;
                        r_cnt    <= r_cnt + CLASS_W'(1);
                    end else begin
                        r_class_idx    <= r_idx;
                        r_max_score    <= r_best;
                        r_second_score <= r_second;
                        r_margin       <= w_margin;
                        r_confident    <= w_confident;
                        r_out_valid    <= 1'b1;
                        r_state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign class_idx    = r_class_idx;
    assign max_score    = r_max_score;
    assign second_score = r_second_score;
    assign margin       = r_margin;
    assign confident    = r_confident;

endmodule
